// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with a registered Gray-code mirror.
//   b    - registered binary count
//   g    - registered Gray code of b, produced from the next binary value so
//          it changes on the same edge as b with no extra latency
//   wrap - one-cycle pulse after an enabled step taken at the count boundary
// Edge priority: rst (async) > load > en > hold.
// Build option: define GRAY_COUNTER_SAT_EN to saturate at the boundaries
// instead of wrapping; wrap still pulses to flag the saturation attempt.
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  output logic             wrap
);

  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] g_next;
  logic             wrap_next;
  logic             at_bound;

  // Next binary value, boundary detection and Gray encoding of the next value.
  always_comb begin
    b_next    = b;
    wrap_next = 1'b0;
    at_bound  = up ? (b == '1) : (b == '0);
    if (load) begin
      b_next = load_val;
    end else if (en) begin
      wrap_next = at_bound;
`ifdef GRAY_COUNTER_SAT_EN
      if (!at_bound) begin
        b_next = up ? b + 1'b1 : b - 1'b1;
      end
`else
      b_next = up ? b + 1'b1 : b - 1'b1;
`endif
    end
    g_next = b_next ^ (b_next >> 1);
  end

  // Count, code and pulse registers; reset clears all three immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b    <= '0;
      g    <= '0;
      wrap <= 1'b0;
    end else begin
      b    <= b_next;
      g    <= g_next;
      wrap <= wrap_next;
    end
  end

endmodule
